ram_dump_arbiter: RTL and testbench
===================================

// Module: ram_dump_arbiter
// PURPOSE
//  Shares the single-port 32-bit program RAM between the CPU data port and a debug dump engine.
//  The dump engine reads a word range and streams it byte-serially, little-endian, to the 8-bit output pins.
//  The CPU has priority. A starvation counter guarantees dump progress.
//  Sits between the risc core, the program RAM and uo_out in the top level.
// PARAMETERS
//  ADDR_W      5   word-address width of program RAM (32 words)
//  DATA_W      32  RAM word width; must be a multiple of 8; BYTES = DATA_W/8
//  STARVE_MAX  7   consecutive denied dump-read cycles before the dump engine is force-granted
// PORTS
//  clk          in   1         clock; all logic on posedge
//  rst          in   1         synchronous reset, active-high
//  cpu_req      in   1         CPU requests RAM access this cycle
//  cpu_we       in   1         CPU write (1) / read (0)
//  cpu_addr     in   ADDR_W    CPU word address
//  cpu_wdata    in   DATA_W    CPU write data
//  cpu_gnt      out  1         CPU access accepted this cycle (comb.)
//  cpu_rdata    out  DATA_W    read data, valid with cpu_rvalid
//  cpu_rvalid   out  1         one-cycle pulse, cycle after a granted read
//  dump_start   in   1         pulse: begin dump
//  dump_base    in   ADDR_W    first word address, sampled on dump_start
//  dump_len     in   ADDR_W+1  word count, 0..2^ADDR_W, sampled on dump_start
//  dump_busy    out  1         dump in progress
//  dump_done    out  1         one-cycle pulse at dump completion
//  byte_out     out  8         streamed byte
//  byte_valid   out  1         byte_out valid
//  byte_ready   in   1         sink accepts byte when valid&&ready
//  ram_we       out  1         RAM write enable (comb.)
//  ram_addr     out  ADDR_W    RAM address (comb. mux)
//  ram_wdata    out  DATA_W    RAM write data (= cpu_wdata)
//  ram_rdata    in   DATA_W    RAM read data, 1-cycle synchronous latency
// BEHAVIOUR
//  - Reset: FSM=IDLE; byte_out=0, byte_valid=0, dump_busy=0, dump_done=0, cpu_rvalid=0, starve_cnt=0; cpu_gnt=0 and ram_we=0 while rst=1.
//  - FSM states: IDLE -> RD (issue read) -> WAIT (capture ram_rdata into shift reg) -> SHIFT (emit BYTES bytes).
//    SHIFT -> RD if words remain, else DONE. DONE -> IDLE (dump_done=1 for exactly that cycle).
//  - Arbitration, per cycle: cpu_gnt = cpu_req && !force.
//    Dump read issues in RD only when !cpu_req or force.
//    force = (state==RD && starve_cnt==STARVE_MAX).
//    When force=1 the CPU is denied and must hold its request.
//  - starve_cnt increments each RD cycle the dump is denied. It clears on dump issue and in IDLE.
//  - ram_addr = dump addr when the dump issues, else cpu_addr. ram_we = cpu_gnt && cpu_we.
//  - cpu_rvalid = registered (cpu_gnt && !cpu_we). cpu_rdata = ram_rdata.
//  - Dump address = (base + word_idx) mod 2^ADDR_W; wraps past the top word.
//  - Bytes go out LSB first (byte 0 = word[7:0]). byte_out/byte_valid hold stable while valid && !ready.
//    On accept the next byte is presented the following cycle, so max throughput is 1 byte/cycle.
//  - Latency: dump_start -> first byte_valid = 3 cycles with no CPU contention (RD, WAIT, SHIFT).
//  - dump_len=0: IDLE -> DONE. dump_done pulses 1 cycle after start, no bytes. dump_busy is high only in that DONE cycle.
//  - dump_busy=1 in all non-IDLE states. dump_start while busy is ignored.
//  - A CPU write to a word not yet dumped is reflected in the dump (no snapshot).
//  - rst asserted mid-dump: immediate return to IDLE, pending byte dropped, no dump_done.
// CONFIGURATION
//  DUMP_CHECKSUM_EN defined:
//    - After the last data byte is accepted, one extra byte is emitted: XOR of all bytes sent in this dump.
//    - dump_done follows its acceptance. For len=0 the checksum byte 0x00 is emitted.
//  DUMP_CHECKSUM_EN undefined:
//    - No extra byte. dump_done pulses the cycle after the final data byte is accepted.
// TESTING
//  - Reset: rst=1 2 cycles with cpu_req=1 -> cpu_gnt=0, ram_we=0, all registered outputs 0.
//  - Dump: RAM[3]=0x44332211, start base=3 len=1, ready=1 -> bytes 11,22,33,44 on 4 consecutive cycles, then dump_done.
//    With DUMP_CHECKSUM_EN, an extra byte 0x44 precedes dump_done.
//  - Wrap: base=31 len=2, RAM[31]=0xA, RAM[0]=0xB -> bytes 0A,00,00,00,0B,00,00,00.
//  - Starvation: cpu_req=1 continuously during dump -> dump read forced after 7 denied cycles.
//    cpu_gnt=0 for exactly 1 cycle; the dump completes.
//  - Backpressure: byte_ready=0 for 5 cycles mid-word -> byte_out stable and no byte lost or duplicated.
//  - CPU read 0xDEADBEEF at addr 5 -> cpu_rvalid pulse next cycle with cpu_rdata=0xDEADBEEF.
//    Also: len=0 -> dump_done 1 cycle after start; rst mid-dump -> IDLE with no dump_done.

Source files
------------

// File: rtl/ram_dump_arbiter_if.sv
// Bus bundle for ram_dump_arbiter: CPU data port, dump control/stream and program-RAM side.
// slave = arbiter view, master = surrounding top level (core, RAM, output pins).
interface ram_dump_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              dump_start;
  logic [ADDR_W-1:0] dump_base;
  logic [ADDR_W:0]   dump_len;
  logic              dump_busy;
  logic              dump_done;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dump_start, dump_base, dump_len,
           byte_ready, ram_rdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid, dump_busy, dump_done, byte_out, byte_valid,
           ram_we, ram_addr, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dump_start, dump_base, dump_len,
           byte_ready, ram_rdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid, dump_busy, dump_done, byte_out, byte_valid,
           ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_dump_arbiter.sv
// Shares the single-port program RAM between the CPU and a byte-serial dump engine (CPU priority,
// starvation-bounded). Optional DUMP_CHECKSUM_EN appends an XOR checksum byte to every dump.
module ram_dump_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk,
  input  logic              rst,
  ram_dump_arbiter_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BYTES - 1);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_MAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [2:0] S_CKSUM = 3'd5;
`endif

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_left;
  logic [SC_W-1:0]   r_starve;
  logic [DATA_W-1:0] r_shift;
  logic [BC_W-1:0]   r_bcnt;
  logic [7:0]        r_byte_out;
  logic              r_byte_valid;
  logic              r_cpu_rvalid;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]        r_cks;
`endif

  logic w_force, w_issue, w_cpu_gnt, w_accept;

  // CPU wins unless the dump has been denied STARVE_MAX read cycles in a row.
  assign w_force   = (r_state == S_RD) && (r_starve == SC_MAX);
  assign w_issue   = (r_state == S_RD) && (!bus.cpu_req || w_force);
  assign w_cpu_gnt = bus.cpu_req && !w_force && !rst;
  assign w_accept  = r_byte_valid && bus.byte_ready;

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.ram_we     = w_cpu_gnt && bus.cpu_we;
  assign bus.ram_addr   = w_issue ? r_addr : bus.cpu_addr;
  assign bus.ram_wdata  = bus.cpu_wdata;
  assign bus.dump_busy  = (r_state != S_IDLE);
  assign bus.dump_done  = (r_state == S_DONE);
  assign bus.byte_out   = r_byte_out;
  assign bus.byte_valid = r_byte_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_left       <= '0;
      r_starve     <= '0;
      r_shift      <= '0;
      r_bcnt       <= '0;
      r_byte_out   <= '0;
      r_byte_valid <= 1'b0;
      r_cpu_rvalid <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      r_cks        <= '0;
`endif
    end else begin
      r_cpu_rvalid <= w_cpu_gnt && !bus.cpu_we;
      case (r_state)
        S_IDLE: begin
          r_starve <= '0;
          if (bus.dump_start) begin
            r_addr <= bus.dump_base;
            r_left <= bus.dump_len;
`ifdef DUMP_CHECKSUM_EN
            r_cks  <= '0;
            if (bus.dump_len == '0) begin
              r_byte_out   <= '0;
              r_byte_valid <= 1'b1;
              r_state      <= S_CKSUM;
            end else begin
              r_state <= S_RD;
            end
`else
            r_state <= (bus.dump_len == '0) ? S_DONE : S_RD;
`endif
          end
        end
        S_RD: begin
          if (w_issue) begin
            r_starve <= '0;
            r_addr   <= r_addr + 1'b1;   // wraps past the top word
            r_left   <= r_left - 1'b1;
            r_state  <= S_WAIT;
          end else begin
            r_starve <= r_starve + 1'b1;
          end
        end
        S_WAIT: begin
          r_byte_out   <= bus.ram_rdata[7:0];
          r_shift      <= bus.ram_rdata >> 8;
          r_byte_valid <= 1'b1;
          r_bcnt       <= '0;
          r_state      <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_accept) begin
`ifdef DUMP_CHECKSUM_EN
            r_cks <= r_cks ^ r_byte_out;
`endif
            if (r_bcnt == BC_LAST) begin
              r_byte_valid <= 1'b0;
              if (r_left != '0) begin
                r_state <= S_RD;
              end else begin
`ifdef DUMP_CHECKSUM_EN
                r_byte_out   <= r_cks ^ r_byte_out;
                r_byte_valid <= 1'b1;
                r_state      <= S_CKSUM;
`else
                r_state <= S_DONE;
`endif
              end
            end else begin
              r_byte_out <= r_shift[7:0];
              r_shift    <= r_shift >> 8;
              r_bcnt     <= r_bcnt + 1'b1;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_CKSUM: begin
          if (w_accept) begin
            r_byte_valid <= 1'b0;
            r_state      <= S_DONE;
          end
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_dump_arbiter.sv
// Randomized and directed bench for ram_dump_arbiter; expected byte streams come from a word-array
// model of the RAM, expanded little-endian per dump (plus XOR byte when DUMP_CHECKSUM_EN).
module tb_ram_dump_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_dump_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_dump_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Program RAM with a side-door loader for preloading
  logic [DW-1:0] mem [32];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  logic [DW-1:0] model_mem [32];
  logic [7:0]    exp_q [$];
  logic [7:0]    got [$];
  int cyc = 0, first_cyc = -1, done_cnt = 0, done_cyc = -1, deny_cnt = 0, deny_cyc = -1;
  int checks = 0, errors = 0;

  // Collector: records accepted bytes, done pulses and denied CPU cycles
  always @(negedge clk) begin
    #2;
    cyc++;
    if (!rst && bus.byte_valid && bus.byte_ready) begin
      if (got.size() == 0) first_cyc = cyc;
      got.push_back(bus.byte_out);
    end
    if (bus.dump_done) begin done_cnt++; done_cyc = cyc; end
    if (!rst && bus.cpu_req && !bus.cpu_gnt) begin deny_cnt++; deny_cyc = cyc; end
  end

  task automatic build_exp(input int b, input int len);
    logic [DW-1:0] w;
    logic [7:0] c;
    c = 8'h00;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      w = model_mem[(b + i) % 32];
      for (int k = 0; k < DW / 8; k++) begin
        exp_q.push_back(w[8*k +: 8]);
        c = c ^ w[8*k +: 8];
      end
    end
    if (CK == 1) exp_q.push_back(c);
  endtask

  function automatic int first_diff();
    if (got.size() != exp_q.size()) return -2;
    foreach (got[i]) if (got[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic poke(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = AW'(a); ld_data = d; model_mem[a] = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic start_dump(input int b, input int len, output int st);
    got.delete(); first_cyc = -1; deny_cnt = 0; deny_cyc = -1;
    build_exp(b, len);
    @(negedge clk);
    bus.dump_start = 1'b1; bus.dump_base = AW'(b); bus.dump_len = (AW+1)'(len);
    #1; st = cyc + 1;
    @(posedge clk); #1;
    bus.dump_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      ok = bus.dump_done;
    end
    #2;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.cpu_gnt !== 1'b0 || bus.ram_we !== 1'b0) begin
        errors++; $display("FAIL reset_gnt cycle %0d got gnt=%b we=%b exp 0 0", i, bus.cpu_gnt, bus.ram_we);
      end
    end
    checks++;
    if ({bus.byte_out, bus.byte_valid, bus.dump_busy, bus.dump_done, bus.cpu_rvalid} !== 12'h0) begin
      errors++;
      $display("FAIL reset_regs got out=%h v=%b busy=%b done=%b rv=%b exp all 0",
               bus.byte_out, bus.byte_valid, bus.dump_busy, bus.dump_done, bus.cpu_rvalid);
    end
    @(negedge clk);
    rst = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
  endtask

  task automatic test_cpu_access();
    logic [DW-1:0] wd;
    poke(5, 32'hDEADBEEF);
    @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 5'd5; #1;
    checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.ram_addr !== 5'd5 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL cpu_rd_gnt got gnt=%b addr=%0d we=%b exp 1 5 0", bus.cpu_gnt, bus.ram_addr, bus.ram_we);
    end
    @(negedge clk); bus.cpu_req = 1'b0; #1;
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL cpu_rd_data got rv=%b data=%h exp 1 deadbeef", bus.cpu_rvalid, bus.cpu_rdata);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL cpu_rv_pulse got %b exp 0", bus.cpu_rvalid);
    end
    wd = $urandom;
    @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 5'd9; bus.cpu_wdata = wd; #1;
    model_mem[9] = wd;
    checks++;
    if (bus.ram_we !== 1'b1 || bus.ram_addr !== 5'd9 || bus.ram_wdata !== wd) begin
      errors++; $display("FAIL cpu_wr got we=%b addr=%0d wdata=%h exp 1 9 %h", bus.ram_we, bus.ram_addr, bus.ram_wdata, wd);
    end
    @(negedge clk); bus.cpu_we = 1'b0; #1;
    checks++;
    if (bus.cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL cpu_wr_norv got %b exp 0", bus.cpu_rvalid);
    end
    @(negedge clk); bus.cpu_req = 1'b0; #1;
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== wd) begin
      errors++; $display("FAIL cpu_wr_rb got rv=%b data=%h exp 1 %h", bus.cpu_rvalid, bus.cpu_rdata, wd);
    end
  endtask

  task automatic test_dump_basic();
    int st, d;
    bit ok;
    poke(3, 32'h44332211);
    bus.byte_ready = 1'b1;
    start_dump(3, 1, st);
    wait_done(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got no dump_done exp done"); end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++; $display("FAIL basic_bytes got n=%0d exp n=%0d diff_idx=%0d", got.size(), exp_q.size(), d);
    end
    checks++;
    if (first_cyc != st + 3 || done_cyc != st + 7 + CK) begin
      errors++; $display("FAIL basic_timing got first=+%0d done=+%0d exp +3 +%0d", first_cyc - st, done_cyc - st, 7 + CK);
    end
  endtask

  task automatic test_wrap();
    int st, d;
    bit ok;
    poke(31, 32'h0000000A);
    poke(0, 32'h0000000B);
    start_dump(31, 2, st);
    wait_done(100, ok);
    d = first_diff();
    checks++;
    if (!ok || d != -1 || got.size() < 5 || got[0] !== 8'h0A || got[4] !== 8'h0B) begin
      errors++; $display("FAIL wrap_bytes got ok=%b n=%0d diff_idx=%0d exp n=%0d", ok, got.size(), d, exp_q.size());
    end
  endtask

  task automatic test_len0();
    int st;
    bit ok;
    start_dump(9, 0, st);
    wait_done(20, ok);
    checks++;
    if (!ok || done_cyc != st + 1 + CK || first_diff() != -1) begin
      errors++; $display("FAIL len0 got ok=%b done=+%0d n=%0d exp done=+%0d n=%0d", ok, done_cyc - st, got.size(), 1 + CK, CK);
    end
  endtask

  task automatic test_starve();
    int st;
    bit ok;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 5'd17;
    start_dump(20, 1, st);
    wait_done(100, ok);
    bus.cpu_req = 1'b0;
    checks++;
    if (!ok || deny_cnt != 1 || deny_cyc != st + 8) begin
      errors++; $display("FAIL starve_force got ok=%b denies=%0d at=+%0d exp 1 at +8", ok, deny_cnt, deny_cyc - st);
    end
    checks++;
    if (first_diff() != -1 || first_cyc != st + 10 || done_cyc != st + 14 + CK) begin
      errors++; $display("FAIL starve_dump got n=%0d first=+%0d done=+%0d exp n=%0d +10 +%0d",
                         got.size(), first_cyc - st, done_cyc - st, exp_q.size(), 14 + CK);
    end
  endtask

  task automatic test_backpressure();
    int st;
    bit ok, hit;
    logic [7:0] b0;
    poke(12, $urandom);
    bus.byte_ready = 1'b1;
    start_dump(12, 1, st);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (got.size() == 2) begin hit = 1'b1; bus.byte_ready = 1'b0; end
    end
    #1; b0 = bus.byte_out;
    checks++;
    if (!hit || b0 !== exp_q[2]) begin
      errors++; $display("FAIL bp_hold_byte got hit=%b byte=%h exp 1 %h", hit, b0, exp_q[2]);
    end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.byte_out !== b0 || bus.byte_valid !== 1'b1) begin
        errors++; $display("FAIL bp_stable cycle %0d got %h v=%b exp %h v=1", i, bus.byte_out, bus.byte_valid, b0);
      end
    end
    @(negedge clk); bus.byte_ready = 1'b1;
    wait_done(50, ok);
    checks++;
    if (!ok || first_diff() != -1) begin
      errors++; $display("FAIL bp_bytes got ok=%b n=%0d diff_idx=%0d exp n=%0d", ok, got.size(), first_diff(), exp_q.size());
    end
  endtask

  task automatic test_rst_mid();
    int st, d0;
    bus.byte_ready = 1'b0;
    start_dump(0, 4, st);
    repeat (5) @(negedge clk);
    rst = 1'b1; bus.cpu_req = 1'b1; #1;
    d0 = done_cnt;
    checks++;
    if (bus.cpu_gnt !== 1'b0 || bus.byte_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_gnt got gnt=%b pend=%b exp 0 1", bus.cpu_gnt, bus.byte_valid);
    end
    @(negedge clk); rst = 1'b0; bus.cpu_req = 1'b0; bus.byte_ready = 1'b1; #1;
    checks++;
    if (bus.dump_busy !== 1'b0 || bus.byte_valid !== 1'b0 || bus.byte_out !== 8'h00) begin
      errors++; $display("FAIL rst_mid_idle got busy=%b v=%b out=%h exp 0 0 00", bus.dump_busy, bus.byte_valid, bus.byte_out);
    end
    repeat (20) @(negedge clk);
    #3;
    checks++;
    if (done_cnt != d0 || got.size() != 0) begin
      errors++; $display("FAIL rst_mid_nodone got dones=%0d bytes=%0d exp 0 0", done_cnt - d0, got.size());
    end
  endtask

  task automatic test_random();
    int st, b, l, d0;
    bit ok, pend;
    logic [AW-1:0] pa;
    for (int n = 0; n < 6; n++) begin
      b = $urandom_range(0, 31);
      l = (n == 0) ? 32 : $urandom_range(0, 32);
      bus.cpu_req = 1'b0;
      d0 = done_cnt;
      start_dump(b, l, st);
      ok = 1'b0; pend = 1'b0; pa = '0;
      for (int c = 0; c < 3000 && !ok; c++) begin
        @(negedge clk);
        bus.byte_ready = ($urandom_range(0, 9) < 7);
        bus.cpu_req    = ($urandom_range(0, 9) < 4);
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = AW'($urandom);
        bus.dump_start = ($urandom_range(0, 7) == 0);
        bus.dump_base  = AW'($urandom);
        bus.dump_len   = (AW+1)'($urandom_range(0, 32));
        #1;
        checks++;
        if (bus.cpu_rvalid !== pend || (pend && bus.cpu_rdata !== model_mem[pa])) begin
          errors++; $display("FAIL rnd_cpu_rd got rv=%b data=%h exp rv=%b data=%h", bus.cpu_rvalid, bus.cpu_rdata, pend, model_mem[pa]);
        end
        pend = bus.cpu_req && bus.cpu_gnt;
        pa = bus.cpu_addr;
        ok = bus.dump_done;
      end
      bus.dump_start = 1'b0; bus.cpu_req = 1'b0;
      #2;
      checks++;
      if (!ok || first_diff() != -1 || done_cnt != d0 + 1) begin
        errors++; $display("FAIL rnd_dump %0d base=%0d len=%0d got ok=%b n=%0d diff_idx=%0d dones=%0d exp n=%0d dones=1",
                           n, b, l, ok, got.size(), first_diff(), done_cnt - d0, exp_q.size());
      end
      checks++;
      if (deny_cnt > l) begin
        errors++; $display("FAIL rnd_deny %0d got %0d denied cycles exp at most %0d", n, deny_cnt, l);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = '0; bus.cpu_wdata = '1;
    bus.dump_start = 1'b0; bus.dump_base = '0; bus.dump_len = '0; bus.byte_ready = 1'b1;
    test_reset();
    for (int a = 0; a < 32; a++) poke(a, $urandom);
    test_cpu_access();
    test_dump_basic();
    test_wrap();
    test_len0();
    test_starve();
    test_backpressure();
    test_rst_mid();
    test_random();
    test_dump_basic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
